adc_snapshot_capture: RTL and testbench
=======================================

Name: adc_snapshot_capture

Overview:
- Triggered snapshot recorder for the 8-bit offset-binary baseband sample produced by the AD9226 front-end conversion stage (65 MHz domain).
- Records DEPTH samples around a level-crossing trigger into a ring buffer, then streams them oldest-first over a valid/ready byte interface to the downstream UART transmitter.
- Gives the team a scope-style view of the modulating signal without stalling the AM path.

Parameters:
DEPTH, 1024, number of samples per snapshot; power of two, at least 4
AW, 10, address width; equals log2(DEPTH)
PRE_TRIG, 64, samples retained before the trigger sample; 0 to DEPTH-1
AUTO_TIMEOUT, 65536, valid samples spent in WAIT_TRIG before a forced trigger (used only with SNAP_AUTO_TRIG_EN)

Ports:
CLK  in  1  sample clock (65 MHz domain)
RST_n  in  1  asynchronous active-low reset
sample_in  in  8  offset-binary sample
sample_valid  in  1  sample_in is valid this cycle
arm  in  1  single-cycle start request; honoured only in IDLE
trig_level  in  8  trigger threshold, sampled at arm
trig_rising  in  1  1 = rising crossing, 0 = falling crossing; sampled at arm
out_data  out  8  readout byte
out_valid  out  1  out_data valid
out_ready  in  1  downstream accepts the byte
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse after the last byte is accepted
trig_auto  out  1  last snapshot was force-triggered (held until next arm)

Behaviour:
- Reset values: out_data=0, out_valid=0, busy=0, done=0, trig_auto=0, state=IDLE. Pointers and counters clear. RAM contents are not reset.
- Reset mid-operation aborts immediately. out_valid drops with no handshake completion.
- States: IDLE, PREFILL, WAIT_TRIG, POST, READOUT.
- IDLE:
  - On arm: latch trig_level and trig_rising; clear wr_ptr and prev_valid.
  - Go to PREFILL, or to WAIT_TRIG when PRE_TRIG=0.
- Writing: in PREFILL, WAIT_TRIG and POST, each sample_valid writes sample_in to RAM[wr_ptr], then wr_ptr increments modulo DEPTH.
- PREFILL: after PRE_TRIG writes, go to WAIT_TRIG. No trigger is evaluated during PREFILL.
- WAIT_TRIG:
  - Keep writing (ring wraps). Keep prev = last written sample; prev_valid is set after the first sample written in this state.
  - Trigger on a valid sample when prev_valid is set and either:
    - rising: prev < level and cur >= level (unsigned)
    - falling: prev > level and cur <= level
  - The trigger sample is written. trig_addr = its address. Go to POST.
- POST: write DEPTH-PRE_TRIG-1 further valid samples, then go to READOUT. When that count is 0, go straight to READOUT.
- READOUT:
  - rd_ptr starts at (trig_addr - PRE_TRIG) mod DEPTH and increments modulo DEPTH.
  - Exactly DEPTH bytes are emitted, oldest first.
  - RAM read latency is 1 cycle. First out_valid is asserted no earlier than 2 cycles after entering READOUT.
  - Handshake:
    - A byte transfers when out_valid && out_ready.
    - While out_valid && !out_ready, out_data holds stable.
    - out_valid never de-asserts without a transfer.
    - Sustained out_ready=1 yields one byte per cycle after the initial latency.
  - sample_valid is ignored. After the DEPTH-th transfer: out_valid=0, done=1 for one cycle, go to IDLE.
- arm outside IDLE is ignored. arm and reset together: reset wins.
- A simultaneous trigger and the wr_ptr wrap in WAIT_TRIG needs no special casing, because the ring arithmetic is modulo DEPTH.

Optional Feature:
- SNAP_AUTO_TRIG_EN defined:
  - A timeout counter counts valid samples in WAIT_TRIG.
  - At AUTO_TIMEOUT, the current valid sample is treated as the trigger sample and trig_auto is set.
  - A real crossing on the same sample takes precedence and leaves trig_auto=0.
- Undefined: no counter; WAIT_TRIG waits indefinitely; trig_auto ties to 0.

Decomposition:
- Package snap_pkg holds:
  - state enum (IDLE, PREFILL, WAIT_TRIG, POST, READOUT)
  - crossing-compare helper function
  - default width constant SAMPLE_W=8
- Sub-module snap_ram: simple dual-port synchronous RAM, DEPTH x 8, one write port, one read port, 1-cycle read latency, no reset; infers M9K.
- Top contains the FSM, pointers and output register.

Test Plan:
- DEPTH=16, PRE_TRIG=4, rising, level=0x80. Ramp 0x00,0x10,... every cycle, out_ready=1 -> trigger on 0x80. Output 0x40,0x50,0x60,0x70,0x80,0x90,...,0xF0,0x00,...0x30 (16 bytes). done pulses once; busy falls.
- Falling trigger, level=0x40, descending ramp with sample_valid toggling every other cycle -> only valid samples are recorded. First byte emitted is 4 samples before the first sample <=0x40.
- out_ready random 30% -> out_data stable during stalls. Exactly 16 transfers, with the byte sequence identical to the out_ready=1 run.
- Ring wrap: constant 0x20 for 50 samples, then a step to 0xA0 -> snapshot spans the wrap. Bytes are 4x 0x20 then 12x 0xA0.
- With SNAP_AUTO_TRIG_EN and AUTO_TIMEOUT=8, constant input 0x10 -> forced trigger on the 8th WAIT_TRIG sample, trig_auto=1, 16 bytes of 0x10. Without the macro, busy stays high and out_valid stays 0.
- RST_n low mid-READOUT after 5 bytes -> out_valid=0, busy=0 immediately. A new arm after release captures normally. arm pulsed during POST has no effect.

Source files
------------

// File: rtl/snap_pkg.sv
// Shared types and helpers for the ADC snapshot recorder.
package snap_pkg;

  localparam int unsigned SAMPLE_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    PREFILL,
    WAIT_TRIG,
    POST,
    READOUT
  } snap_state_e;

  // Unsigned level-crossing test between two consecutive samples.
  function automatic logic crossing(input logic [SAMPLE_W-1:0] prev,
                                    input logic [SAMPLE_W-1:0] cur,
                                    input logic [SAMPLE_W-1:0] level,
                                    input logic                rising);
    if (rising) return (prev < level) && (cur >= level);
    return (prev > level) && (cur <= level);
  endfunction

endpackage

// File: rtl/snap_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port, no reset.
module snap_ram
  import snap_pkg::*;
#(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic                clk,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [SAMPLE_W-1:0] wr_data,
  input  logic                rd_en,
  input  logic [AW-1:0]       rd_addr,
  output logic [SAMPLE_W-1:0] rd_data
);

  logic [SAMPLE_W-1:0] mem [DEPTH];

  // rd_data holds its value while rd_en is low; the readout path relies on this.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/adc_snapshot_capture.sv
// Triggered snapshot recorder: ring-buffer capture around a level crossing, byte readout.
// Optional forced trigger after a timeout is enabled with `define SNAP_AUTO_TRIG_EN.
module adc_snapshot_capture
  import snap_pkg::*;
#(
  parameter int unsigned DEPTH        = 1024,
  parameter int unsigned AW           = 10,
  parameter int unsigned PRE_TRIG     = 64,
  parameter int unsigned AUTO_TIMEOUT = 65536
) (
  input  logic                CLK,
  input  logic                RST_n,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                sample_valid,
  input  logic                arm,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_rising,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                busy,
  output logic                done,
  output logic                trig_auto
);

  localparam int unsigned CW        = AW + 1;
  localparam logic [CW-1:0] PRE_CNT   = CW'(PRE_TRIG);
  localparam logic [CW-1:0] POST_CNT  = CW'(DEPTH - PRE_TRIG - 1);
  localparam logic [CW-1:0] XFER_CNT  = CW'(DEPTH);
  localparam logic [CW-1:0] XFER_LAST = CW'(DEPTH - 1);
  localparam logic [AW-1:0] PRE_OFS   = AW'(PRE_TRIG);

  if (((32'd1 << AW) != DEPTH) || (DEPTH < 4) || (PRE_TRIG >= DEPTH) ||
      (AUTO_TIMEOUT == 0)) begin : g_param_chk
    $error("adc_snapshot_capture: inconsistent DEPTH/AW/PRE_TRIG/AUTO_TIMEOUT");
  end

`ifdef SNAP_AUTO_TRIG_EN
  localparam int unsigned   TW       = $clog2(AUTO_TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(AUTO_TIMEOUT - 1);
  logic [TW-1:0] tmo, tmo_d;
`endif

  snap_state_e         state, state_d;
  logic [SAMPLE_W-1:0] level, level_d;
  logic                rising, rising_d;
  logic [AW-1:0]       wr_ptr, wr_ptr_d;
  logic [AW-1:0]       rd_ptr, rd_ptr_d;
  logic [CW-1:0]       cnt, cnt_d;
  logic [CW-1:0]       xfer_cnt, xfer_cnt_d;
  logic [SAMPLE_W-1:0] prev, prev_d;
  logic                prev_valid, prev_valid_d;
  logic                q_valid, q_valid_d;
  logic [SAMPLE_W-1:0] out_data_d;
  logic                out_valid_d, busy_d, done_d, trig_auto_d;

  logic                wr_en_c, rd_en_c, hit_c, auto_c, load_c, xfer_c;
  logic [CW-1:0]       cnt_inc_c;
  logic [SAMPLE_W-1:0] ram_q;

  snap_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
    .clk     (CLK),
    .wr_en   (wr_en_c),
    .wr_addr (wr_ptr),
    .wr_data (sample_in),
    .rd_en   (rd_en_c),
    .rd_addr (rd_ptr),
    .rd_data (ram_q)
  );

  // State and datapath registers.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state      <= IDLE;
      level      <= '0;
      rising     <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      xfer_cnt   <= '0;
      prev       <= '0;
      prev_valid <= 1'b0;
      q_valid    <= 1'b0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      trig_auto  <= 1'b0;
`ifdef SNAP_AUTO_TRIG_EN
      tmo        <= '0;
`endif
    end else begin
      state      <= state_d;
      level      <= level_d;
      rising     <= rising_d;
      wr_ptr     <= wr_ptr_d;
      rd_ptr     <= rd_ptr_d;
      cnt        <= cnt_d;
      xfer_cnt   <= xfer_cnt_d;
      prev       <= prev_d;
      prev_valid <= prev_valid_d;
      q_valid    <= q_valid_d;
      out_data   <= out_data_d;
      out_valid  <= out_valid_d;
      busy       <= busy_d;
      done       <= done_d;
      trig_auto  <= trig_auto_d;
`ifdef SNAP_AUTO_TRIG_EN
      tmo        <= tmo_d;
`endif
    end
  end

  // Next-state and output logic.
  always_comb begin
    state_d      = state;
    level_d      = level;
    rising_d     = rising;
    wr_ptr_d     = wr_ptr;
    rd_ptr_d     = rd_ptr;
    cnt_d        = cnt;
    xfer_cnt_d   = xfer_cnt;
    prev_d       = prev;
    prev_valid_d = prev_valid;
    q_valid_d    = q_valid;
    out_data_d   = out_data;
    out_valid_d  = out_valid;
    busy_d       = busy;
    done_d       = 1'b0;
    trig_auto_d  = trig_auto;
`ifdef SNAP_AUTO_TRIG_EN
    tmo_d        = tmo;
`endif
    wr_en_c      = 1'b0;
    rd_en_c      = 1'b0;
    hit_c        = 1'b0;
    auto_c       = 1'b0;
    load_c       = 1'b0;
    xfer_c       = out_valid && out_ready;
    cnt_inc_c    = cnt + CW'(1);

    case (state)
      IDLE: begin
        if (arm) begin
          level_d      = trig_level;
          rising_d     = trig_rising;
          wr_ptr_d     = '0;
          prev_valid_d = 1'b0;
          cnt_d        = '0;
          xfer_cnt_d   = '0;
          q_valid_d    = 1'b0;
          trig_auto_d  = 1'b0;
          busy_d       = 1'b1;
`ifdef SNAP_AUTO_TRIG_EN
          tmo_d        = '0;
`endif
          state_d      = (PRE_TRIG == 0) ? WAIT_TRIG : PREFILL;
        end
      end

      PREFILL: begin
        if (sample_valid) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr + AW'(1);
          cnt_d    = cnt_inc_c;
          if (cnt_inc_c == PRE_CNT) begin
            cnt_d   = '0;
            state_d = WAIT_TRIG;
          end
        end
      end

      WAIT_TRIG: begin
        if (sample_valid) begin
          wr_en_c      = 1'b1;
          wr_ptr_d     = wr_ptr + AW'(1);
          prev_d       = sample_in;
          prev_valid_d = 1'b1;
          hit_c        = prev_valid && crossing(prev, sample_in, level, rising);
`ifdef SNAP_AUTO_TRIG_EN
          auto_c       = (tmo == TMO_LAST);
          tmo_d        = tmo + TW'(1);
`endif
          // A real crossing wins over the timeout on the same sample.
          if (hit_c || auto_c) begin
            trig_auto_d = auto_c && !hit_c;
            rd_ptr_d    = wr_ptr - PRE_OFS;
            cnt_d       = '0;
            state_d     = (POST_CNT == '0) ? READOUT : POST;
          end
        end
      end

      POST: begin
        if (sample_valid) begin
          wr_en_c  = 1'b1;
          wr_ptr_d = wr_ptr + AW'(1);
          cnt_d    = cnt_inc_c;
          if (cnt_inc_c == POST_CNT) begin
            cnt_d   = '0;
            state_d = READOUT;
          end
        end
      end

      READOUT: begin
        // Two-stage pipe: RAM output register (q_valid) feeds the output register.
        load_c  = q_valid && (!out_valid || out_ready);
        rd_en_c = (cnt != XFER_CNT) && (!q_valid || load_c);
        if (rd_en_c) begin
          rd_ptr_d = rd_ptr + AW'(1);
          cnt_d    = cnt_inc_c;
        end
        if (rd_en_c)     q_valid_d = 1'b1;
        else if (load_c) q_valid_d = 1'b0;
        if (xfer_c) begin
          xfer_cnt_d  = xfer_cnt + CW'(1);
          out_valid_d = 1'b0;
        end
        if (load_c) begin
          out_data_d  = ram_q;
          out_valid_d = 1'b1;
        end
        if (xfer_c && (xfer_cnt == XFER_LAST)) begin
          out_valid_d = 1'b0;
          done_d      = 1'b1;
          busy_d      = 1'b0;
          state_d     = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_adc_snapshot_capture.sv
// Directed bench for adc_snapshot_capture (DEPTH=16, PRE_TRIG=4, AUTO_TIMEOUT=8).
module tb_adc_snapshot_capture;

  localparam int unsigned DEPTH        = 16;
  localparam int unsigned AW           = 4;
  localparam int unsigned PRE_TRIG     = 4;
  localparam int unsigned AUTO_TIMEOUT = 8;

  logic       CLK = 1'b0;
  logic       RST_n = 1'b0;
  logic [7:0] sample_in = '0;
  logic       sample_valid = 1'b0;
  logic       arm = 1'b0;
  logic [7:0] trig_level = '0;
  logic       trig_rising = 1'b0;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       busy;
  logic       done;
  logic       trig_auto;

  adc_snapshot_capture #(
    .DEPTH(DEPTH), .AW(AW), .PRE_TRIG(PRE_TRIG), .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) dut (
    .CLK          (CLK),
    .RST_n        (RST_n),
    .sample_in    (sample_in),
    .sample_valid (sample_valid),
    .arm          (arm),
    .trig_level   (trig_level),
    .trig_rising  (trig_rising),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .busy         (busy),
    .done         (done),
    .trig_auto    (trig_auto)
  );

  always #5 CLK = ~CLK;

  int n_total = 0;
  int n_bad   = 0;

  logic [7:0] got_bytes [$];
  bit         got_done;
  bit         saw_valid;

  logic [7:0] exp_ramp [16] = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0,
                                8'hC0, 8'hD0, 8'hE0, 8'hF0, 8'h00, 8'h10, 8'h20, 8'h30};
  logic [7:0] exp_fall [16] = '{8'h80, 8'h70, 8'h60, 8'h50, 8'h40, 8'h30, 8'h20, 8'h10,
                                8'h00, 8'hF0, 8'hE0, 8'hD0, 8'hC0, 8'hB0, 8'hA0, 8'h90};
  logic [7:0] exp_wrap [16] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'hA0, 8'hA0, 8'hA0, 8'hA0,
                                8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0, 8'hA0};
  logic [7:0] exp_c20  [16] = '{8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20,
                                8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20, 8'h20};
  logic [7:0] exp_c10  [16] = '{8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10,
                                8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10, 8'h10};
  logic [7:0] exp_arm  [16] = '{8'h40, 8'h50, 8'h60, 8'h70, 8'h80, 8'h90, 8'hA0, 8'hB0,
                                8'hC0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hF0};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Sample stream for each directed scenario, indexed by cycle since arm.
  function automatic logic [7:0] gen(input int mode, input int cyc, output logic v);
    v = 1'b1;
    case (mode)
      0:       return 8'(cyc * 16);
      1: begin v = (cyc % 2 == 0); return 8'(240 - 8 * cyc); end
      3:       return (cyc < 50) ? 8'h20 : 8'hA0;
      4:       return 8'h10;
      5:       return (cyc <= 12) ? 8'(cyc * 16) : 8'hF0;
      default: return 8'h00;
    endcase
  endfunction

  task automatic capture(input int mode, input logic [7:0] lvl, input logic rise,
                         input int rdy_pct, input int arm_cyc, input int stop_after,
                         input int budget);
    logic       v;
    logic [7:0] s;
    logic       stall;
    logic [7:0] hold_d;
    got_bytes.delete();
    got_done  = 1'b0;
    saw_valid = 1'b0;
    stall     = 1'b0;
    hold_d    = '0;
    @(negedge CLK);
    trig_level   = lvl;
    trig_rising  = rise;
    sample_valid = 1'b0;
    out_ready    = 1'b0;
    arm          = 1'b1;
    @(negedge CLK);
    arm = 1'b0;
    chk("busy_after_arm", 32'(busy), 32'd1);
    for (int cyc = 0; cyc < budget; cyc++) begin
      if (cyc > 0) @(negedge CLK);
      arm          = 1'b0;
      sample_valid = 1'b0;
      if (stop_after > 0 && got_bytes.size() == stop_after) return;
      if (stall) begin
        chk("stall_valid", 32'(out_valid), 32'd1);
        chk("stall_data", 32'(out_data), 32'(hold_d));
      end
      if (done) begin
        got_done = 1'b1;
        @(negedge CLK);
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("busy_after_done", 32'(busy), 32'd0);
        return;
      end
      s            = gen(mode, cyc, v);
      sample_in    = s;
      sample_valid = v;
      arm          = (cyc == arm_cyc);
      out_ready    = (rdy_pct >= 100) ? 1'b1 : ($urandom_range(0, 99) < rdy_pct);
      if (out_valid) saw_valid = 1'b1;
      if (out_valid && out_ready) got_bytes.push_back(out_data);
      stall  = out_valid && !out_ready;
      hold_d = out_data;
    end
    arm          = 1'b0;
    sample_valid = 1'b0;
  endtask

  task automatic check_snap(input string tag, input logic [7:0] exp [16], input logic auto_exp);
    chk({tag, "_done"}, 32'(got_done), 32'd1);
    chk({tag, "_count"}, 32'(got_bytes.size()), 32'd16);
    for (int i = 0; i < 16; i++) begin
      if (i < got_bytes.size())
        chk($sformatf("%s_byte%0d", tag, i), 32'(got_bytes[i]), 32'(exp[i]));
    end
    chk({tag, "_trig_auto"}, 32'(trig_auto), 32'(auto_exp));
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_trig_auto", 32'(trig_auto), 32'd0);
    RST_n = 1'b1;

    capture(0, 8'h80, 1'b1, 100, -1, 0, 400);
    check_snap("ramp", exp_ramp, 1'b0);

    capture(1, 8'h40, 1'b0, 100, -1, 0, 400);
    check_snap("fall", exp_fall, 1'b0);

    capture(0, 8'h80, 1'b1, 30, -1, 0, 1000);
    check_snap("stall", exp_ramp, 1'b0);

    capture(3, 8'h80, 1'b1, 100, -1, 0, 400);
`ifdef SNAP_AUTO_TRIG_EN
    check_snap("wrap", exp_c20, 1'b1);
`else
    check_snap("wrap", exp_wrap, 1'b0);
`endif

    capture(4, 8'h80, 1'b1, 100, -1, 0, 200);
`ifdef SNAP_AUTO_TRIG_EN
    check_snap("auto", exp_c10, 1'b1);
`else
    chk("noauto_done", 32'(got_done), 32'd0);
    chk("noauto_valid", 32'(saw_valid), 32'd0);
    chk("noauto_busy", 32'(busy), 32'd1);
    chk("noauto_trig_auto", 32'(trig_auto), 32'd0);
    @(negedge CLK);
    RST_n = 1'b0;
    @(negedge CLK);
    RST_n = 1'b1;
`endif

    capture(0, 8'h80, 1'b1, 100, -1, 5, 400);
    chk("midrst_bytes", 32'(got_bytes.size()), 32'd5);
    RST_n = 1'b0;
    #1;
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    @(negedge CLK);
    RST_n = 1'b1;

    capture(5, 8'h80, 1'b1, 100, 12, 0, 400);
    check_snap("armpost", exp_arm, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
